pwm_dac: RTL and testbench
==========================

# pwm_dac

Output stage that consumes the 8-bit signed sine amplitude from the NCO and drives a single-bit PWM pin for an external RC reconstruction filter. It applies an unsigned gain, converts the result to offset-binary duty and generates a 256-cycle PWM frame. The new duty value is loaded only at frame boundaries, so the pin never glitches mid-frame. The block sits between the NCO output and the board pin.

## Interface
- No parameters; widths are fixed (8-bit sample, 8-bit gain, 256-cycle frame).
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  run request; sampled only as described in Operation.
- amplitude  in  8  signed two's-complement sample (NCO output).
- gain  in  8  unsigned gain; 0xFF ≈ unity, 0x00 = mute.
- pwm  out  1  PWM pin.
- period_start  out  1  one-cycle pulse during frame cycle 0.
- duty  out  8  duty value currently in force (offset binary).
- pwm_n  out  1  complementary pin; present only with PWM_DAC_PWMN_EN.

## Operation
- Scale register `scaled_q` (8-bit signed):
  - Updated every clk from the current inputs: `scaled_q` <= (amplitude × {1'b0,gain}) >>> 8.
  - 16-bit signed product; arithmetic shift, so the result is floored.
  - Result range −128..126; no saturation is needed.
- Duty conversion: duty value = `scaled_q` with MSB inverted (XOR 0x80), giving 0x00..0xFE.
- FSM with two states, IDLE and RUN.
- IDLE:
  - cnt = 0, pwm = 0, period_start = 0, duty holds its last value.
  - If enable = 1 at an edge: load duty from `scaled_q`, set cnt <= 0, set period_start <= 1, go to RUN.
- RUN:
  - Each edge: cnt <= cnt + 1 (8-bit), period_start <= 0.
  - At the edge where cnt == 0xFF (frame end):
    - cnt wraps to 0.
    - If enable = 1: load a new duty and set period_start <= 1.
    - If enable = 0: go to IDLE.
  - enable deasserting mid-frame has no effect until the frame ends; every frame completes.
- pwm = (state == RUN) && (cnt < duty). It is decoded only from flops.
  - duty 0x00 → never high.
  - duty 0x80 → high for 128 of 256 cycles.
- amplitude and gain changes mid-frame never alter the current frame.

## Timing
- Reset values: state IDLE, cnt 0x00, duty 0x80, `scaled_q` 0x00, pwm 0, period_start 0, pwm_n 0.
- Input-to-scaled latency: 1 clk.
- The duty loaded at a frame-end edge uses amplitude and gain sampled at the preceding edge (cnt == 0xFE). Total latency from input to pin is 2 clk plus the wait for the frame boundary.
- Frame length: exactly 256 clk in RUN.
- period_start is high during the cycle in which cnt == 0.
- The first RUN cycle is cnt = 0, with period_start = 1 and pwm = (0 < duty).
- Asynchronous reset mid-frame forces the reset values at once. Restart occurs only after reset falls and enable is seen at an edge.
- enable toggling while in IDLE: the block acts on the first edge where enable = 1; no filtering is applied.

## Configuration
- PWM_DAC_PWMN_EN defined:
  - Adds port pwm_n = (state == RUN) && !(cnt < duty).
  - pwm_n is the exact complement of pwm while in RUN and 0 in IDLE and during reset.
- PWM_DAC_PWMN_EN undefined: port pwm_n does not exist. All other behaviour is identical.

## Test plan
- Reset: assert reset mid-simulation with enable = 1 → pwm = 0, period_start = 0, duty = 0x80 in the same cycle, before any clk edge.
- amplitude 0x00, gain 0xFF, enable = 1 → duty 0x80; pwm high 128 cycles then low 128; period_start pulses every 256 clk.
- Extremes at gain 0xFF:
  - amplitude 0x7F → duty 0xFE, pwm high 254 of 256.
  - amplitude 0x81 → duty 0x01, high 1 cycle.
  - amplitude 0x80 → duty 0x00, pwm never high.
- Gain 0x00 with any amplitude → duty 0x80. Gain 0x01 with amplitude 0xFF → `scaled_q` −1, duty 0x7F.
- amplitude changed 0x00→0x7F at cnt 0x40 → current frame keeps duty 0x80; the next frame shows 0xFE.
- enable dropped at cnt 0x10 → frame runs to cnt 0xFF, then IDLE with pwm = 0; with PWM_DAC_PWMN_EN, pwm_n = ~pwm throughout RUN and 0 in IDLE.

Source files
------------

// File: rtl/pwm_dac_if.sv
// pwm_dac_if: groups the sample/gain/enable inputs and the PWM outputs of
// pwm_dac. Optional macro PWM_DAC_PWMN_EN adds the complementary pin pwm_n.
interface pwm_dac_if;
    logic       enable;
    logic [7:0] amplitude;
    logic [7:0] gain;
    logic       pwm;
    logic       period_start;
    logic [7:0] duty;
`ifdef PWM_DAC_PWMN_EN
    logic       pwm_n;
`endif

    // Source side: drives the run request, sample and gain; observes the pin.
    modport master (
        output enable,
        output amplitude,
        output gain,
        input  pwm,
        input  period_start,
`ifdef PWM_DAC_PWMN_EN
        input  pwm_n,
`endif
        input  duty
    );

    // PWM stage side.
    modport slave (
        input  enable,
        input  amplitude,
        input  gain,
        output pwm,
        output period_start,
`ifdef PWM_DAC_PWMN_EN
        output pwm_n,
`endif
        output duty
    );
endinterface

// File: rtl/pwm_dac.sv
// pwm_dac: scales a signed 8-bit sample by an unsigned gain, converts it to
// offset-binary duty and drives a 256-cycle PWM frame. Duty is only loaded
// at frame boundaries so the pin never glitches mid-frame.
// Optional macro PWM_DAC_PWMN_EN adds the complementary output pwm_n.
module pwm_dac (
    input  logic       clk,
    input  logic       reset,
    pwm_dac_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [7:0]         cnt_reg, cnt_next;
    logic [7:0]         duty_reg, duty_next;
    logic               period_start_reg, period_start_next;
    logic signed [7:0]  scaled_reg;
    logic signed [7:0]  scaled_next;
    logic signed [15:0] product;
    logic [7:0]         duty_conv;
    logic               run;
    logic               below_duty;

    // Signed sample times zero-extended gain; the full-scale product
    // (-128*255 .. 127*255) fits in 16 bits, and the arithmetic shift floors.
    assign product     = $signed(bus.amplitude) * $signed({1'b0, bus.gain});
    assign scaled_next = 8'(product >>> 8);

    // Scale register: one-cycle latency from inputs, updated every clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scaled_reg <= '0;
        end else begin
            scaled_reg <= scaled_next;
        end
    end

    // Offset-binary conversion: invert the sign bit, pass the rest through.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_conv
            if (gi == 7) begin : g_msb
                assign duty_conv[gi] = ~scaled_reg[gi];
            end else begin : g_lsb
                assign duty_conv[gi] = scaled_reg[gi];
            end
        end
    endgenerate

    // State, frame counter, duty and frame-start pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= 8'h00;
            duty_reg         <= 8'h80;
            period_start_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            duty_reg         <= duty_next;
            period_start_reg <= period_start_next;
        end
    end

    // Next-state logic: start on enable, load duty only at frame boundaries,
    // and let a frame always run to completion before returning to IDLE.
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        duty_next         = duty_reg;
        period_start_next = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = 8'h00;
                if (bus.enable) begin
                    duty_next         = duty_conv;
                    period_start_next = 1'b1;
                    state_next        = RUN;
                end
            end
            RUN: begin
                cnt_next = cnt_reg + 8'h01;
                if (cnt_reg == 8'hFF) begin
                    if (bus.enable) begin
                        duty_next         = duty_conv;
                        period_start_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pin decode purely from registered state so the outputs are glitch-free
    // relative to the clock and drop immediately on reset.
    assign run        = (state_reg == RUN);
    assign below_duty = (cnt_reg < duty_reg);

    assign bus.pwm          = run && below_duty;
    assign bus.period_start = period_start_reg;
    assign bus.duty         = duty_reg;
`ifdef PWM_DAC_PWMN_EN
    assign bus.pwm_n        = run && !below_duty;
`endif

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: directed scoreboard bench for pwm_dac. Expected duty values are
// pushed when new amplitude/gain is driven and popped at each frame start.
module tb_pwm_dac;

    logic clk;
    logic reset;

    pwm_dac_if bus ();

    pwm_dac dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         tests_run = 0;
    int         failures  = 0;
    logic [7:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe one 256-cycle frame; at cycle chg_at drive the next inputs.
    task automatic observe_frame(input int chg_at, input bit en,
                                 input logic [7:0] amp, input logic [7:0] gn,
                                 input bit push, input logic [7:0] exp_next);
        logic [7:0] exp;
        int         highs;
        bit         ps_ok, duty_ok, pat_ok, n_ok;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        exp     = (sb.size() != 0) ? sb.pop_front() : 8'h80;
        highs   = 0;
        ps_ok   = 1'b1;
        duty_ok = 1'b1;
        pat_ok  = 1'b1;
        n_ok    = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (bus.pwm === 1'b1) highs++;
            if (bus.period_start !== (i == 0)) ps_ok = 1'b0;
            if (bus.duty !== exp) duty_ok = 1'b0;
            if (bus.pwm !== (i < int'(exp))) pat_ok = 1'b0;
`ifdef PWM_DAC_PWMN_EN
            if (bus.pwm_n !== !(i < int'(exp))) n_ok = 1'b0;
`endif
            if (i == chg_at) begin
                bus.enable    = en;
                bus.amplitude = amp;
                bus.gain      = gn;
                if (push) sb.push_back(exp_next);
            end
        end
        check("frame_period_start", 32'(ps_ok), 32'd1);
        check("frame_duty", 32'(duty_ok ? exp : bus.duty), 32'(exp));
        check("frame_pattern", 32'(pat_ok), 32'd1);
        check("frame_high_count", 32'(highs), 32'(exp));
`ifdef PWM_DAC_PWMN_EN
        check("frame_pwm_n", 32'(n_ok), 32'd1);
`endif
        $display("[TB] frame duty=%02h high_cycles=%0d", exp, highs);
    endtask

    initial begin
        bool_dummy();
        // Power-on reset: outputs must be at reset values before any edge.
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.amplitude = 8'h00;
        bus.gain      = 8'hFF;
        #1;
        check("por_pwm", 32'(bus.pwm), 32'd0);
        check("por_period_start", 32'(bus.period_start), 32'd0);
        check("por_duty", 32'(bus.duty), 32'h80);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Load midscale sample, let it reach the scale register, then start.
        sb.push_back(8'h80);
        repeat (2) @(negedge clk);
        check("idle_pwm", 32'(bus.pwm), 32'd0);
        bus.enable = 1'b1;

        // Each frame: amplitude/gain change at cnt 0x40 must only affect the next frame.
        observe_frame(8'h40, 1'b1, 8'h7F, 8'hFF, 1'b1, 8'hFE);
        observe_frame(8'h40, 1'b1, 8'h81, 8'hFF, 1'b1, 8'h01);
        observe_frame(8'h40, 1'b1, 8'h80, 8'hFF, 1'b1, 8'h00);
        observe_frame(8'h40, 1'b1, 8'h5A, 8'h00, 1'b1, 8'h80);
        observe_frame(8'h40, 1'b1, 8'hFF, 8'h01, 1'b1, 8'h7F);
        observe_frame(8'h40, 1'b1, 8'h40, 8'h80, 1'b1, 8'hA0);
        observe_frame(8'h40, 1'b1, 8'hC0, 8'h80, 1'b1, 8'h60);
        // Drop enable at cnt 0x10: the frame still completes.
        observe_frame(8'h10, 1'b0, 8'hC0, 8'h80, 1'b0, 8'h00);

        // Back in IDLE: pin low, no pulse, duty held.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_after_pwm", 32'(bus.pwm), 32'd0);
            check("idle_after_ps", 32'(bus.period_start), 32'd0);
            check("idle_after_duty", 32'(bus.duty), 32'h60);
`ifdef PWM_DAC_PWMN_EN
            check("idle_after_pwm_n", 32'(bus.pwm_n), 32'd0);
`endif
        end
        $display("[TB] idle after enable drop duty=%02h", bus.duty);

        // Restart, then hit asynchronous reset mid-frame with enable held.
        sb.push_back(8'h60);
        bus.enable = 1'b1;
        @(negedge clk);
        check("restart_ps", 32'(bus.period_start), 32'd1);
        check("restart_duty", 32'(bus.duty), 32'(sb.pop_front()));
        check("restart_pwm", 32'(bus.pwm), 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_pwm", 32'(bus.pwm), 32'd0);
        check("async_rst_ps", 32'(bus.period_start), 32'd0);
        check("async_rst_duty", 32'(bus.duty), 32'h80);
`ifdef PWM_DAC_PWMN_EN
        check("async_rst_pwm_n", 32'(bus.pwm_n), 32'd0);
`endif
        $display("[TB] async reset mid-frame duty=%02h pwm=%0b", bus.duty, bus.pwm);
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_pwm", 32'(bus.pwm), 32'd0);
        check("post_rst_duty", 32'(bus.duty), 32'h80);
        check("post_rst_ps", 32'(bus.period_start), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    task automatic bool_dummy();
    endtask

endmodule
